// File: rtl/sa_drain_if.sv
// rtl/sa_drain_if.sv - row-tagged result stream between sa_drain and its downstream consumer
interface sa_drain_if #(
    parameter int COLS    = 4,
    parameter int C_WIDTH = 16,
    parameter int ROW_W   = 2
);
    logic                      o_valid;
    logic                      i_ready;
    logic [COLS*C_WIDTH-1:0]   o_data;
    logic [ROW_W-1:0]          o_row_idx;

    modport master (output o_valid, output o_data, output o_row_idx, input i_ready);
    modport slave  (input o_valid, input o_data, input o_row_idx, output i_ready);
endinterface

// File: rtl/sa_drain.sv
// rtl/sa_drain.sv - systolic array result drain: shift control, result FIFO, row-tagged stream
// Optional SA_DRAIN_RELU_EN: negative lanes are clamped to zero at FIFO write.
module sa_drain #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int C_WIDTH    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_ctrl_sa_send_data,
    input  logic [COLS*C_WIDTH-1:0] i_col_c,
    sa_drain_if.master              res
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = COLS * C_WIDTH;
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t         state;
    logic [RW-1:0]  cnt;
    logic [DW-1:0]  mem_data [FIFO_DEPTH];
    logic [RW-1:0]  mem_row  [FIFO_DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [PW:0]    count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [DW-1:0]  wdata;
    logic [RW-1:0]  row_w;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign row_w = LAST_ROW - cnt;

    // Outputs are forced low while reset is asserted so the reset cycle itself is clean.
    assign o_ctrl_sa_send_data = !i_rst && (state == DRAIN) && !full;
    assign o_busy              = !i_rst && (state != IDLE);
    assign o_done              = !i_rst && (state == FLUSH) && empty;
    assign res.o_valid         = !i_rst && !empty;
    assign res.o_data          = res.o_valid ? mem_data[rptr] : '0;
    assign res.o_row_idx       = res.o_valid ? mem_row[rptr]  : '0;

    assign push = o_ctrl_sa_send_data;
    assign pop  = res.o_valid && res.i_ready;

`ifdef SA_DRAIN_RELU_EN
    always_comb begin
        wdata = i_col_c;
        for (int k = 0; k < COLS; k++) begin
            if (i_col_c[k*C_WIDTH + C_WIDTH - 1]) begin
                wdata[k*C_WIDTH +: C_WIDTH] = '0;
            end
        end
    end
`else
    assign wdata = i_col_c;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    if (o_ctrl_sa_send_data) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ROW) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data[wptr] <= wdata;
            mem_row[wptr]  <= row_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_drain.sv
// tb/tb_sa_drain.sv - scoreboard bench for sa_drain with a shift-chain model of the array
module tb_sa_drain;
    localparam int ROWS  = 4;
    localparam int COLS  = 2;
    localparam int CW    = 16;
    localparam int DEPTH = 2;
    localparam int RW    = 2;

    typedef struct {
        logic [RW-1:0]      row;
        logic [COLS*CW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, send;
    logic [COLS*CW-1:0] col_c;

    always #5 clk = ~clk;

    sa_drain_if #(.COLS(COLS), .C_WIDTH(CW), .ROW_W(RW)) sif ();

    sa_drain #(.ROWS(ROWS), .COLS(COLS), .C_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start),
        .o_busy              (busy),
        .o_done              (done),
        .o_ctrl_sa_send_data (send),
        .i_col_c             (col_c),
        .res                 (sif)
    );

    // Array model: each column is a shift chain whose bottom row feeds i_col_c.
    logic [CW-1:0] chain [ROWS][COLS];
    logic [CW-1:0] pre   [ROWS][COLS];
    logic          load_req = 1'b0;

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                if (load_req) chain[r][k] <= pre[r][k];
                else if (send) chain[r][k] <= (r == 0) ? '0 : chain[(r == 0) ? 0 : r-1][k];
            end
        end
    end

    always_comb begin
        col_c = '0;
        for (int k = 0; k < COLS; k++) col_c[k*CW +: CW] = chain[ROWS-1][k];
    end

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   shifts = 0, dones = 0;
    int   first_shift = -1, last_shift = -1, last_pop = -1, done_cyc = -1;
    bit   mon_en = 1'b0;
    bit   hold_prev = 1'b0;
    logic [COLS*CW-1:0] prev_data;
    logic [RW-1:0]      prev_row;
    logic [COLS*CW-1:0] exp_top;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (send) begin
                if (first_shift < 0) first_shift = cyc;
                last_shift = cyc;
                shifts++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (hold_prev) begin
                checks++;
                if (sif.o_data !== prev_data || sif.o_row_idx !== prev_row) begin
                    errors++;
                    $display("FAIL hold_stable: got row=%0d data=%h, required row=%0d data=%h",
                             sif.o_row_idx, sif.o_data, prev_row, prev_data);
                end
            end
            if (sif.o_valid && sif.i_ready) begin
                last_pop = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got row=%0d data=%h, required none",
                             sif.o_row_idx, sif.o_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (sif.o_row_idx !== mon_e.row || sif.o_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL output_vector: got row=%0d data=%h, required row=%0d data=%h",
                                 sif.o_row_idx, sif.o_data, mon_e.row, mon_e.data);
                    end
                end
            end
        end
        hold_prev = mon_en && sif.o_valid && !sif.i_ready;
        prev_data = sif.o_data;
        prev_row  = sif.o_row_idx;
    end

    function automatic logic [CW-1:0] relu(input logic [CW-1:0] v);
`ifdef SA_DRAIN_RELU_EN
        return v[CW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prepare(input int kind);
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                case (kind)
                    0:       pre[r][k] = CW'(2*r + k + 1);
                    1:       pre[r][k] = CW'($urandom());
                    default: pre[r][k] = (k == 0) ? CW'(16'hFFFF - r) : CW'(16'h0005 + r);
                endcase
            end
        end
        for (int r = ROWS-1; r >= 0; r--) begin
            e.row  = RW'(r);
            e.data = '0;
            for (int k = 0; k < COLS; k++) e.data[k*CW +: CW] = relu(pre[r][k]);
            if (r == ROWS-1) exp_top = e.data;
            sb.push_back(e);
        end
    endtask

    task automatic clear_counters();
        shifts = 0; dones = 0;
        first_shift = -1; last_shift = -1; last_pop = -1; done_cyc = -1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({busy, done, send, sif.o_valid} !== 4'b0 || sif.o_data !== '0 || sif.o_row_idx !== '0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b send=%b valid=%b data=%h row=%0d, required all 0",
                     tag, busy, done, send, sif.o_valid, sif.o_data, sif.o_row_idx);
        end
    endtask

    // Loads the chain and pulses i_start in the same cycle, then runs to o_done.
    task automatic run_drain(input string tag, input int kind, input int hold, input bit alt, input bit hold_start);
        bit seen;
        seen = 1'b0;
        clear_counters();
        mon_en = 1'b1;
        prepare(kind);
        sif.i_ready = (hold > 0 || alt) ? 1'b0 : 1'b1;
        load_req = 1'b1;
        start = 1'b1;
        tick();
        load_req = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_rise: got %b required 1", tag, busy);
        end
        for (int c = 1; c <= 300; c++) begin
            if (dones > 0) begin
                seen = 1'b1;
                break;
            end
            if (hold_start) start = (c >= 2);
            if (alt) sif.i_ready = ~sif.i_ready;
            else if (c >= hold) sif.i_ready = 1'b1;
            if (hold > 0 && c == hold - 1) begin
                checks++;
                if (shifts !== 2 || send !== 1'b0 || sif.o_valid !== 1'b1 ||
                    sif.o_row_idx !== RW'(ROWS-1) || sif.o_data !== exp_top) begin
                    errors++;
                    $display("FAIL %s_stall: got shifts=%0d send=%b valid=%b row=%0d data=%h, required shifts=2 send=0 valid=1 row=%0d data=%h",
                             tag, shifts, send, sif.o_valid, sif.o_row_idx, sif.o_data, ROWS-1, exp_top);
                end
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no o_done, required o_done within 300 cycles", tag);
        end
        checks++;
        if (shifts !== ROWS || dones !== 1) begin
            errors++;
            $display("FAIL %s_counts: got shifts=%0d dones=%0d, required shifts=%0d dones=1", tag, shifts, dones, ROWS);
        end
        checks++;
        if (done_cyc !== last_pop + 1) begin
            errors++;
            $display("FAIL %s_done_timing: got done at %0d last pop at %0d, required done one cycle after pop",
                     tag, done_cyc, last_pop);
        end
        checks++;
        if (sb.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end_state: got pending=%0d busy=%b, required pending=0 busy=0", tag, sb.size(), busy);
        end
        if (!alt && hold == 0) begin
            checks++;
            if (last_shift - first_shift !== ROWS - 1) begin
                errors++;
                $display("FAIL %s_consecutive: got span=%0d, required %0d", tag, last_shift - first_shift, ROWS - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.i_ready = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset_held");
        rst = 1'b0;
        tick();
        check_idle_outputs("reset_released");
    endtask

    task automatic test_basic_drain();
        run_drain("basic", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_drain("backpressure", 1, 10, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_drain("start_busy", 1, 0, 1'b0, 1'b1);
        run_drain("restart", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        clear_counters();
        mon_en = 1'b1;
        prepare(1);
        sif.i_ready = 1'b1;
        load_req = 1'b1;
        start = 1'b1;
        tick();
        load_req = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 20 && shifts < 2; c++) tick();
        checks++;
        if (shifts !== 2) begin
            errors++;
            $display("FAIL reset_mid_shifts: got %0d, required 2", shifts);
        end
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("reset_mid");
        sb.delete();
        run_drain("after_reset", 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_relu();
        run_drain("relu", 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_alternating();
        run_drain("alternating", 1, 0, 1'b1, 1'b0);
        run_drain("alternating2", 2, 0, 1'b1, 1'b0);
    endtask

    initial begin
        sif.i_ready = 1'b1;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_relu();
        test_alternating();
        mon_en = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish before 200000");
        $fatal(1);
    end
endmodule
